// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt sequencer.
//   - CP0 event type codes
//   - sequencer FSM state encoding
//   - Status register bit positions
//   - exc_type(): priority-resolved type code for a detected event
package exc_pkg;

    localparam logic [2:0] T_ERET   = 3'b010;
    localparam logic [2:0] T_SYS    = 3'b100;
    localparam logic [2:0] T_SYS_DS = 3'b101;
    localparam logic [2:0] T_INT    = 3'b110;
    localparam logic [2:0] T_INT_DS = 3'b111;
    localparam logic [2:0] T_RI     = 3'b011;
    localparam logic [2:0] T_RI_DS  = 3'b001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IM_LO = 10;
    localparam int unsigned ST_IM_HI = 15;

    // Priority: interrupt > RI > SYSCALL > ERET.
    function automatic logic [2:0] exc_type(input logic take_int, input logic take_ri,
                                            input logic take_sys, input logic in_ds);
        logic [2:0] t;
        if (take_int)      t = in_ds ? T_INT_DS : T_INT;
        else if (take_ri)  t = in_ds ? T_RI_DS  : T_RI;
        else if (take_sys) t = in_ds ? T_SYS_DS : T_SYS;
        else               t = T_ERET;
        return t;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for the external interrupt lines.
//   clk, rst : clock, synchronous active-high reset
//   irq_in   : asynchronous level interrupt lines
//   irq_out  : synchronised lines, two cycles behind irq_in
module irq_sync #(
    parameter int unsigned NUM_IRQ = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] irq_out
);

    logic [NUM_IRQ-1:0] meta_q;
    logic [NUM_IRQ-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= irq_in;
            sync_q <= meta_q;
        end
    end

    assign irq_out = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the MEM stage and CP0.
// Detects interrupt/RI/SYSCALL/ERET in IDLE, then runs COMMIT -> FLUSH -> REDIRECT.
//   clk, rst                  : clock, synchronous active-high reset
//   irq_in                    : asynchronous interrupt lines
//   mem_*                     : MEM-stage instruction info and event flags
//   cp0_status/ebase/epc      : current CP0 register values
//   cp0_we/type/excaddr       : exception write to CP0 (strobe valid in COMMIT only)
//   irq_pending               : synchronised interrupt lines for Cause.IP
//   stall, flush              : pipeline control
//   redirect_valid/pc         : one-cycle fetch redirect
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_OFFSET = 32'h0000_0180,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned NUM_IRQ        = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mem_valid,
    input  logic [31:0]        mem_pc,
    input  logic               mem_in_ds,
    input  logic               mem_syscall,
    input  logic               mem_ri,
    input  logic               mem_eret,
    input  logic [31:0]        cp0_status,
    input  logic [31:0]        cp0_ebase,
    input  logic [31:0]        cp0_epc,
    output logic               cp0_we,
    output logic [2:0]         cp0_type,
    output logic [31:0]        cp0_excaddr,
    output logic [NUM_IRQ-1:0] irq_pending,
    output logic               stall,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc
);

    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] excaddr_q, excaddr_d;
    logic [31:0] target_q, target_d;

    logic take_int, take_ri, take_sys, take_eret, take_any;

    // Only IE, EXL and IM are decoded here.
    logic unused_status;
    assign unused_status = ^cp0_status;

    irq_sync #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_sync (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .irq_out (irq_pending)
    );

    assign take_int  = mem_valid & cp0_status[ST_IE] & ~cp0_status[ST_EXL] &
                       (|(irq_pending & cp0_status[ST_IM_LO +: NUM_IRQ]));
    assign take_ri   = mem_valid & mem_ri;
    assign take_sys  = mem_valid & mem_syscall;
    assign take_eret = mem_valid & mem_eret;
    assign take_any  = take_int | take_ri | take_sys | take_eret;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            type_q    <= '0;
            excaddr_q <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            excaddr_q <= excaddr_d;
            target_q  <= target_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        excaddr_d = excaddr_q;
        target_d  = target_q;
        unique case (state_q)
            IDLE: begin
                if (take_any) begin
                    type_d    = exc_type(take_int, take_ri, take_sys, mem_in_ds);
                    excaddr_d = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
                    // ERET only wins when no exception is present.
                    target_d  = (take_int | take_ri | take_sys) ?
                                (cp0_ebase + HANDLER_OFFSET) : cp0_epc;
                    state_d   = COMMIT;
                end
            end
            COMMIT: begin
                cnt_d   = FlushInit;
                // COMMIT already counts as the first flush cycle.
                state_d = (FlushInit == 4'd0) ? REDIRECT : FLUSH;
            end
            FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cp0_we         = (state_q == COMMIT);
        stall          = (state_q != IDLE);
        flush          = (state_q == COMMIT) || (state_q == FLUSH);
        redirect_valid = (state_q == REDIRECT);
        redirect_pc    = (state_q == REDIRECT) ? target_q : 32'd0;
        cp0_type       = type_q;
        cp0_excaddr    = excaddr_q;
    end

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  irq_in;
    logic        mem_valid, mem_in_ds, mem_syscall, mem_ri, mem_eret;
    logic [31:0] mem_pc, cp0_status, cp0_ebase, cp0_epc;
    logic        cp0_we, stall, flush, redirect_valid;
    logic [2:0]  cp0_type;
    logic [31:0] cp0_excaddr, redirect_pc;
    logic [5:0]  irq_pending;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    exc_ctrl #(
        .HANDLER_OFFSET (32'h0000_0180),
        .FLUSH_CYCLES   (2),
        .NUM_IRQ        (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_in_ds      (mem_in_ds),
        .mem_syscall    (mem_syscall),
        .mem_ri         (mem_ri),
        .mem_eret       (mem_eret),
        .cp0_status     (cp0_status),
        .cp0_ebase      (cp0_ebase),
        .cp0_epc        (cp0_epc),
        .cp0_we         (cp0_we),
        .cp0_type       (cp0_type),
        .cp0_excaddr    (cp0_excaddr),
        .irq_pending    (irq_pending),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic        valid, sys, ri, eret, ds;
        logic [5:0]  irq;
        logic [31:0] pc, status, ebase, epc;
        logic        take;
        logic [2:0]  typ;
        logic [31:0] addr, tgt;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic valid, sys, ri, eret, ds, input logic [5:0] irq,
                                input logic [31:0] pc, status, ebase, epc,
                                input logic take, input logic [2:0] typ,
                                input logic [31:0] addr, tgt);
        vec_t v;
        v.valid = valid; v.sys = sys; v.ri = ri; v.eret = eret; v.ds = ds; v.irq = irq;
        v.pc = pc; v.status = status; v.ebase = ebase; v.epc = epc;
        v.take = take; v.typ = typ; v.addr = addr; v.tgt = tgt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        irq_in = '0; mem_valid = 0; mem_pc = '0; mem_in_ds = 0; mem_syscall = 0;
        mem_ri = 0; mem_eret = 0; cp0_status = '0; cp0_ebase = '0; cp0_epc = '0;
    endtask

    task automatic present(input vec_t v);
        mem_valid = v.valid; mem_syscall = v.sys; mem_ri = v.ri; mem_eret = v.eret;
        mem_in_ds = v.ds; mem_pc = v.pc; cp0_status = v.status; cp0_ebase = v.ebase;
        cp0_epc = v.epc;
    endtask

    task automatic chk_ctl(input string name, input int idx, input logic we, input logic fl,
                           input logic st, input logic rv);
        chk({name, ".we"}, idx, {31'd0, cp0_we}, {31'd0, we});
        chk({name, ".flush"}, idx, {31'd0, flush}, {31'd0, fl});
        chk({name, ".stall"}, idx, {31'd0, stall}, {31'd0, st});
        chk({name, ".redir"}, idx, {31'd0, redirect_valid}, {31'd0, rv});
    endtask

    initial begin
        localparam logic [31:0] EB = 32'h8000_0000;
        localparam logic [31:0] HV = 32'h8000_0180;
        int we_count;
        //             val sys ri  er  ds  irq    pc             status         ebase
        vecs[0]  = mk(1, 1, 0, 0, 0, 6'h00, 32'h0000_1000, 32'h0, EB, 32'h0,
                      1, 3'b100, 32'h0000_1000, HV);
        vecs[1]  = mk(1, 1, 0, 0, 1, 6'h00, 32'h0000_2004, 32'h0, EB, 32'h0,
                      1, 3'b101, 32'h0000_2000, HV);
        vecs[2]  = mk(1, 0, 0, 0, 0, 6'h01, 32'h0000_4000, 32'h0000_0401, EB, 32'h0,
                      1, 3'b110, 32'h0000_4000, HV);
        vecs[3]  = mk(1, 0, 0, 0, 0, 6'h01, 32'h0000_4000, 32'h0000_0403, EB, 32'h0,
                      0, 3'b000, 32'h0, 32'h0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 6'h01, 32'h0000_4000, 32'h0000_0001, EB, 32'h0,
                      0, 3'b000, 32'h0, 32'h0);
        vecs[5]  = mk(1, 1, 0, 0, 0, 6'h01, 32'h0000_4100, 32'h0000_0401, EB, 32'h0,
                      1, 3'b110, 32'h0000_4100, HV);
        vecs[6]  = mk(1, 0, 1, 0, 1, 6'h00, 32'h0000_5008, 32'h0, EB, 32'h0,
                      1, 3'b001, 32'h0000_5004, HV);
        vecs[7]  = mk(1, 0, 1, 0, 0, 6'h00, 32'h0000_5008, 32'h0, EB, 32'h0,
                      1, 3'b011, 32'h0000_5008, HV);
        vecs[8]  = mk(1, 0, 0, 1, 0, 6'h00, 32'h0000_6000, 32'h0, EB, 32'h0000_3000,
                      1, 3'b010, 32'h0000_6000, 32'h0000_3000);
        vecs[9]  = mk(1, 0, 0, 0, 1, 6'h20, 32'h0000_7004, 32'h0000_8001, EB, 32'h0,
                      1, 3'b111, 32'h0000_7000, HV);
        vecs[10] = mk(1, 1, 0, 0, 1, 6'h00, 32'h0000_0000, 32'h0, 32'hFFFF_FF00, 32'h0,
                      1, 3'b101, 32'hFFFF_FFFC, 32'h0000_0080);
        vecs[11] = mk(1, 1, 1, 1, 0, 6'h00, 32'h0000_9000, 32'h0, EB, 32'h0000_3000,
                      1, 3'b011, 32'h0000_9000, HV);
        vecs[12] = mk(0, 1, 0, 0, 0, 6'h00, 32'h0000_1000, 32'h0, EB, 32'h0,
                      0, 3'b000, 32'h0, 32'h0);

        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;

        // Reset state
        chk_ctl("reset", 0, 0, 0, 0, 0);
        chk("reset.type", 0, {29'd0, cp0_type}, 32'd0);
        chk("reset.excaddr", 0, cp0_excaddr, 32'd0);
        chk("reset.rpc", 0, redirect_pc, 32'd0);
        chk("reset.pend", 0, {26'd0, irq_pending}, 32'd0);

        // Synchroniser lag: pending follows irq_in two edges later
        irq_in = 6'h01;
        tick();
        chk("sync.lag1", 0, {26'd0, irq_pending}, 32'd0);
        tick();
        chk("sync.lag2", 0, {26'd0, irq_pending}, 32'd1);
        irq_in = '0;
        tick(); tick(); tick();

        for (int i = 0; i < NV; i++) begin
            irq_in = vecs[i].irq;
            tick(); tick(); tick();
            present(vecs[i]);
            tick();
            idle_inputs();
            if (vecs[i].take) begin
                chk_ctl("commit", i, 1, 1, 1, 0);
                chk("commit.type", i, {29'd0, cp0_type}, {29'd0, vecs[i].typ});
                chk("commit.excaddr", i, cp0_excaddr, vecs[i].addr);
                tick();
                chk_ctl("flush", i, 0, 1, 1, 0);
                tick();
                chk_ctl("redirect", i, 0, 0, 1, 1);
                chk("redirect.pc", i, redirect_pc, vecs[i].tgt);
                tick();
                chk_ctl("idle", i, 0, 0, 0, 0);
                chk("hold.type", i, {29'd0, cp0_type}, {29'd0, vecs[i].typ});
                chk("hold.excaddr", i, cp0_excaddr, vecs[i].addr);
            end else begin
                for (int c = 0; c < 4; c++) begin
                    chk_ctl("notake", i, 0, 0, 0, 0);
                    tick();
                end
            end
            tick(); tick(); tick();
        end

        // ERET held through the sequence: only one CP0 write
        present(mk(1, 0, 0, 1, 0, 6'h00, 32'h0000_6000, 32'h0, EB, 32'h0000_3000,
                   1, 3'b010, 32'h0, 32'h0));
        we_count = 0;
        tick();
        if (cp0_we) we_count++;
        chk("eret2.commit_type", 0, {29'd0, cp0_type}, 32'd2);
        cp0_epc = 32'h0000_7777;
        tick();
        if (cp0_we) we_count++;
        chk_ctl("eret2.flush", 0, 0, 1, 1, 0);
        tick();
        if (cp0_we) we_count++;
        chk("eret2.rpc", 0, redirect_pc, 32'h0000_3000);
        idle_inputs();
        tick();
        if (cp0_we) we_count++;
        chk("eret2.we_count", 0, we_count, 1);
        tick(); tick();

        // Reset during FLUSH abandons the sequence
        present(vecs[0]);
        tick();
        idle_inputs();
        tick();
        chk_ctl("rstflush.pre", 0, 0, 1, 1, 0);
        rst = 1;
        tick();
        rst = 0;
        chk_ctl("rstflush.post", 0, 0, 0, 0, 0);
        chk("rstflush.type", 0, {29'd0, cp0_type}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_ctl("rstflush.after", c, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer that sits between the pipeline MEM stage and the CP0 register file.
- Samples syscall, reserved-instruction, eret and external interrupt events, and prioritises them.
- Drives the CP0 exception-write strobe, type and excaddr, then flushes the pipeline and redirects fetch to the handler or to EPC.
- Owns the only path by which EPC, Status.EXL and Cause.ExcCode/BD change on an exception.

Parameters:
- HANDLER_OFFSET, 32'h0000_0180, handler vector offset added to EBase.
- FLUSH_CYCLES, 2, number of cycles flush stays asserted (1..15).
- NUM_IRQ, 6, number of external interrupt lines.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- irq_in  in  NUM_IRQ  asynchronous external interrupt lines, level.
- mem_valid  in  1  the MEM-stage instruction is valid.
- mem_pc  in  32  PC of the MEM-stage instruction.
- mem_in_ds  in  1  the MEM-stage instruction is in a branch delay slot.
- mem_syscall  in  1  MEM-stage instruction is SYSCALL.
- mem_ri  in  1  MEM-stage instruction is a reserved instruction.
- mem_eret  in  1  MEM-stage instruction is ERET.
- cp0_status  in  32  current Status register.
- cp0_ebase  in  32  current EBase register.
- cp0_epc  in  32  current EPC register.
- cp0_we  out  1  exception-write strobe to CP0.
- cp0_type  out  3  event type to CP0.
- cp0_excaddr  out  32  EPC value to load.
- irq_pending  out  NUM_IRQ  synchronised interrupt lines, which feed CP0 Cause.IP.
- stall  out  1  freezes IF..MEM.
- flush  out  1  kills IF..MEM contents.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, synchroniser flops 0, captured registers 0. Reset asserted in any state returns to IDLE at the next edge with every output 0; a partial flush or redirect is abandoned.
- Interrupt synchroniser: 2-flop per line, so irq_pending lags irq_in by 2 cycles.
- An interrupt is taken when all of the following hold:
  - cp0_status[0] = 1 (IE);
  - cp0_status[1] = 0 (EXL);
  - (irq_pending & cp0_status[15:10]) != 0;
  - mem_valid = 1.
- Priority, evaluated in IDLE only, with mem_valid = 1: interrupt > RI > SYSCALL > ERET.
- Synchronous exceptions are taken regardless of EXL.
- Events arriving in any state other than IDLE are ignored; the pipeline is stalled, so they are re-presented afterwards.
- Type codes (CP0 decodes these):
  - ERET = 3'b010.
  - SYSCALL = 3'b100, or 3'b101 in a delay slot.
  - INT = 3'b110, or 3'b111 in a delay slot.
  - RI = 3'b011, or 3'b001 in a delay slot.
- excaddr is mem_pc, or mem_pc - 4 when mem_in_ds = 1 (mod 2^32; wrap at 0 is permitted). For interrupts the MEM instruction is not executed; EPC points at it.
- FSM:
  - IDLE: when an event is detected, capture the type and excaddr. Capture the target: cp0_ebase + HANDLER_OFFSET (32-bit, wraps) for exceptions, cp0_epc for ERET. Then go to COMMIT. stall = 0.
  - COMMIT (1 cycle): cp0_we = 1 and cp0_type/cp0_excaddr valid; stall = 1, flush = 1. Next state is FLUSH.
  - FLUSH: flush = 1 and stall = 1 for FLUSH_CYCLES-1 further cycles, counted by a 4-bit down-counter. Next state is REDIRECT.
  - REDIRECT (1 cycle): redirect_valid = 1, redirect_pc = captured target, stall = 1, flush = 0. Next state is IDLE.
- Total latency from detection to redirect strobe: 1 + FLUSH_CYCLES cycles.
- cp0_type and cp0_excaddr hold their captured values until the next capture.
- Outside COMMIT, cp0_we is 0.
- The ERET target is sampled at detection, so a simultaneous software write to EPC in the same cycle is not seen.

Decomposition:
- Shared package exc_pkg:
  - type codes (T_ERET, T_SYS, T_SYS_DS, T_INT, T_INT_DS, T_RI, T_RI_DS);
  - FSM state encoding (IDLE, COMMIT, FLUSH, REDIRECT);
  - Status bit indices (IE = 0, EXL = 1, IM = 15:10).
- Natural sub-module: irq_sync, a parameterised NUM_IRQ-wide 2-flop synchroniser.

Test Plan:
- SYSCALL at mem_pc = 0x0000_1000, mem_in_ds = 0, ebase = 0x8000_0000:
  - COMMIT: cp0_we = 1 for one cycle, type = 3'b100, excaddr = 0x1000;
  - flush high for 2 cycles;
  - redirect_pc = 0x8000_0180 on cycle 3.
- SYSCALL in a delay slot at mem_pc = 0x2004: type = 3'b101, excaddr = 0x2000.
- Interrupt masking:
  - irq_in[0] = 1 with status = 0x0000_0401: irq_pending[0] rises 2 cycles later, then an interrupt is taken with type = 3'b110;
  - repeat with status[1] = 1 or status[10] = 0: no cp0_we and no flush.
- Same cycle, interrupt enabled and mem_syscall = 1: the interrupt wins (type = 3'b110); the syscall is ignored during the sequence.
- ERET with cp0_epc = 0x0000_3000: type = 3'b010, redirect_pc = 0x3000; a second ERET presented during FLUSH produces no second cp0_we.
- rst asserted during FLUSH: next cycle flush, stall, cp0_we and redirect_valid are all 0 and the FSM is in IDLE; no redirect occurs.
